// File: rtl/shift_add_pkg.sv
// Shared types and constants for the shift-add multiplier slice.
package shift_add_pkg;

    localparam int SHIFT_ADD_DEFAULT_N = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } shift_add_state_t;

endpackage

// File: rtl/shift_add_ctrl_if.sv
// Start/operand/result bundle between a requester and shift_add_ctrl.
interface shift_add_ctrl_if #(
    parameter int N = 4
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_ctrl_counter.sv
// Team loadable up/down counter: load has priority over en; up_down=1 counts up.
module counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic         up_down,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] count
);
    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= data_in;
        end else if (en) begin
            r_count <= up_down ? r_count + ONE : r_count - ONE;
        end
    end

    assign count = r_count;
endmodule

// File: rtl/shift_add_ctrl.sv
// Sequential unsigned shift-add multiplier and its sequencer.
// Optional SHIFT_ADD_SKIP_ZERO_EN: skip the ADD state for zero multiplier bits.
module shift_add_ctrl
    import shift_add_pkg::*;
#(
    parameter int N = SHIFT_ADD_DEFAULT_N
) (
    input  logic             clk,
    input  logic             rst,
    shift_add_ctrl_if.slave  bus
);
    localparam int            CW     = $clog2(N + 1);
    localparam logic [CW-1:0] ITERS  = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    shift_add_state_t r_state;
    shift_add_state_t w_next;

    logic [N-1:0]   r_m;
    logic [N:0]     r_a;
    logic [N-1:0]   r_q;
    logic [2*N-1:0] r_product;

    logic           w_load;
    logic           w_dec;
    logic [CW-1:0]  w_count;
    logic           w_last;
    logic [N:0]     w_sum;

    assign w_sum  = r_a + {1'b0, r_m};
    assign w_last = (w_count == CNT_ONE);

    counter #(
        .N (CW)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .en      (w_dec),
        .up_down (1'b0),
        .data_in (ITERS),
        .count   (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_load = 1'b1;
`ifdef SHIFT_ADD_SKIP_ZERO_EN
                w_next = bus.b[0] ? ADD : SHIFT;
`else
                w_next = ADD;
`endif
            end
            ADD: begin
                w_next = SHIFT;
            end
            SHIFT: begin
                w_dec = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end else begin
`ifdef SHIFT_ADD_SKIP_ZERO_EN
                    // Q[1] becomes Q[0] once this shift lands.
                    w_next = r_q[1] ? ADD : SHIFT;
`else
                    w_next = ADD;
`endif
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_m <= bus.a;
                    r_q <= bus.b;
                    r_a <= '0;
                end
                ADD: begin
                    if (r_q[0]) begin
                        r_a <= w_sum;
                    end
                end
                SHIFT: begin
                    r_a <= {1'b0, r_a[N:1]};
                    r_q <= {r_a[0], r_q[N-1:1]};
                end
                DONE: begin
                    r_product <= {r_a[N-1:0], r_q};
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = (r_state == LOAD) || (r_state == ADD) || (r_state == SHIFT);
    assign bus.done    = (r_state == DONE);
    assign bus.product = r_product;
endmodule

// File: tb/tb_shift_add_ctrl.sv
// Scoreboard bench for shift_add_ctrl: stimulus pushes expected results, a monitor checks them.
module tb_shift_add_ctrl;
    import shift_add_pkg::*;

    localparam int N = SHIFT_ADD_DEFAULT_N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_add_ctrl_if #(.N(N)) bus ();

    shift_add_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*N-1:0] prod;
        int             done_cyc;
    } exp_t;

    typedef struct {
        int a;
        int b;
        int prod;
        int lat_fixed;
        int lat_skip;
    } vec_t;

    exp_t sb[$];

    // a, b, product, done cycle (fixed), done cycle (skip-zero = N+popcount(b)+2)
    vec_t vecs [7] = '{
        '{13, 11, 143, 10,  9},
        '{15, 15, 225, 10, 10},
        '{ 0,  9,   0, 10,  8},
        '{ 9,  0,   0, 10,  6},
        '{13,  8, 104, 10,  7},
        '{ 1,  1,   1, 10,  7},
        '{15,  1,  15, 10,  7}
    };

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input vec_t v);
`ifdef SHIFT_ADD_SKIP_ZERO_EN
        return v.lat_skip;
`else
        return v.lat_fixed;
`endif
    endfunction

    task automatic push_exp(input vec_t v, input int done_cyc);
        exp_t e;
        e.prod     = v.prod[2*N-1:0];
        e.done_cyc = done_cyc;
        sb.push_back(e);
    endtask

    // Monitor: checks done timing on the pulse, product one cycle later.
    logic           pending = 1'b0;
    logic [2*N-1:0] pend_prod = '0;

    always @(negedge clk) begin
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                check("product", bus.product, pend_prod);
                pending = 1'b0;
            end
            if (bus.done) begin
                check("busy_done_exclusive", bus.busy, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    pend_prod = e.prod;
                    pending   = 1'b1;
                end
            end
        end
    end

    task automatic run_op(input vec_t v);
        int c0;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        bus.a     = v.a[N-1:0];
        bus.b     = v.b[N-1:0];
        bus.start = 1'b1;
        c0        = cyc;
        push_exp(v, c0 + lat(v));
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt  = 0;
        seen      = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                @(negedge clk);
            end
        end
        check("done_seen", seen, 1);
        check("busy_cycles", busy_cnt, lat(v) - 1);
        @(negedge clk);
    endtask

    task automatic run_held_start(input vec_t v);
        int c0;
        int l;
        @(negedge clk);
        bus.a     = v.a[N-1:0];
        bus.b     = v.b[N-1:0];
        bus.start = 1'b1;
        c0        = cyc;
        l         = lat(v);
        push_exp(v, c0 + l);
        push_exp(v, c0 + 2 * l + 1);
        repeat (l + 1) @(negedge clk);
        check("held_idle_after_done", bus.busy, 0);
        @(negedge clk);
        check("held_reload", bus.busy, 1);
        bus.start = 1'b0;
        repeat (l + 1) @(negedge clk);
        check("held_no_third_op", bus.busy, 0);
    endtask

    task automatic run_reset_mid_op(input vec_t v);
        int done_cnt;
        @(negedge clk);
        bus.a     = v.a[N-1:0];
        bus.b     = v.b[N-1:0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_reset", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_product", bus.product, 0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);
        check("rst_idle_busy", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_product", bus.product, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);

        foreach (vecs[i]) run_op(vecs[i]);
        run_held_start(vecs[0]);
        run_reset_mid_op(vecs[0]);

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_add_ctrl.md
# shift_add_ctrl

Sequential unsigned shift-add multiplier with its own controller. It captures two N-bit operands on a start request and runs the classic add/shift loop over N iterations. It reports the 2N-bit product with a one-cycle done pulse. The iteration count is held in the team's loadable up/down counter (`counter`), which this block loads and decrements. This block is the top-level sequencer of the multiplier datapath.

## Interface
Parameters:
- N, 4, operand width in bits (N ≥ 2)

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  N  multiplicand, captured in LOAD
- b  input  N  multiplier, captured in LOAD
- busy  output  1  high in LOAD, ADD, SHIFT
- done  output  1  one-cycle pulse in DONE
- product  output  2N  result; updated only in DONE, held until the next DONE

## Operation
- Registers:
  - M: N bits, multiplicand.
  - A: N+1 bits, accumulator including carry.
  - Q: N bits, multiplier/low product.
- Iteration counter: `counter` instance, up_down=0, data_in=N, load driven in LOAD, en driven in SHIFT.
- FSM states: IDLE, LOAD, ADD, SHIFT, DONE.
- IDLE:
  - start=1 → LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - M←a, Q←b, A←0, counter←N.
  - Next state is ADD.
- ADD:
  - If Q[0]=1, A←A+M, computed at N+1 bits with no overflow loss.
  - If Q[0]=0, A is unchanged.
  - Next state is SHIFT.
- SHIFT:
  - {A,Q} ← {A,Q} >> 1, with a zero shifted into A's MSB.
  - Counter decrements.
  - Counter value 1 before the decrement → DONE; otherwise → ADD.
- DONE:
  - product ← {A[N-1:0], Q}, done=1.
  - Next state is IDLE unconditionally.
- start outside IDLE (LOAD, ADD, SHIFT, DONE) is ignored. It is not queued.
- a and b are don't-care outside the LOAD cycle.
- Reset values:
  - State IDLE.
  - busy=0, done=0, product=0.
  - M, A, Q and counter all 0.
- Reset mid-operation: the operation is abandoned and the block enters IDLE immediately. No done pulse is produced for the abandoned operation.
- Result bounds: the product always fits in 2N bits; A[N] is 0 at DONE.
- Edge operands: a=0 or b=0 gives product 0 with normal latency.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycle 1: LOAD, busy=1.
- Cycles 2..2N+1: alternating ADD/SHIFT, N pairs.
- Cycle 2N+2: DONE. done=1, busy=0, and the product register updates at the end of this cycle.
- product is visible on the output from cycle 2N+3 onward.
- Earliest next start: sampled in cycle 2N+3 (IDLE).
- busy and done are never high in the same cycle.
- All outputs are registered or decoded from the registered state. There is no combinational path from start to any output.

## Configuration
- SHIFT_ADD_SKIP_ZERO_EN
  - Defined: the ADD state is bypassed when the Q[0] value in effect for the next iteration is 0.
    - The next-state logic in LOAD uses b[0]; in SHIFT it uses Q[1].
    - ADD is entered only for 1-bits.
    - DONE falls in cycle N+popcount(b)+2.
  - Undefined: fixed latency. ADD is always visited and DONE falls in cycle 2N+2.
  - The product value is identical in both builds.

## Structure
- Package shift_add_pkg:
  - State enum typedef shift_add_state_t (IDLE, LOAD, ADD, SHIFT, DONE).
  - Default width constant SHIFT_ADD_DEFAULT_N=4.
- Sub-module: one `counter` instance (N=$clog2(N+1) bits wide) for the iteration count. All other logic stays in shift_add_ctrl.

## Test plan
All scenarios use N=4 with the macro undefined unless stated otherwise.
- a=13, b=11, start pulse:
  - busy high cycles 1–9.
  - done in cycle 10.
  - product=143 (0x8F).
- a=15, b=15: product=225 (0xE1). Check that the A carry into bit N is handled correctly.
- a=0, b=9, then a=9, b=0: product=0 for both, done in cycle 10 each time.
- Start held high through a full operation, including DONE: exactly one operation runs.
  - Next LOAD occurs in cycle 12 (start sampled in IDLE at cycle 11).
  - No early restart.
- rst asserted in cycle 5 of an operation:
  - State goes to IDLE immediately.
  - busy=0, product=0.
  - No done pulse follows.
- Macro defined, a=13, b=8 (popcount 1): done in cycle 7, product=104.
